// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and defaults for the 8N1 UART
//
// Purpose : FSM state constants used by both uart_tx and uart_rx, plus the
//           default baud divide.
// Ports   : none (package).

package uart_pkg;

  // Default clk cycles per serial bit; must be >= 4 and even.
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // TX and RX FSMs share one 2-bit encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 deserializer with centre-of-bit sampling
//
// Purpose : synchronizes rx, validates the start bit at its centre, samples
//           8 data bits LSB first and checks the stop bit.
// Ports   : clk     - system clock, rising edge
//           rst     - asynchronous active-high reset
//           rx      - serial input, asynchronous to clk, idle high
//           rx_data - last correctly framed byte, held until the next one
//           rx_done - one-cycle pulse when rx_data updates

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          wait_high;  // framing error seen, waiting for line to idle

  // Reset to 1 so the synchronizer looks like an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      wait_high <= 1'b0;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt       <= '0;
          wait_high <= 1'b0;
          if (!rx_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          // Re-check at mid start bit; a high line here was only a glitch.
          // Restarting cnt here puts every later sample at a bit centre.
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin  // ST_STOP
          if (wait_high) begin
            if (rx_s) begin
              wait_high <= 1'b0;
              state     <= ST_IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              wait_high <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serializer with fixed integer baud divide
//
// Purpose : sends one start bit, 8 data bits LSB first and one stop bit per
//           accepted tx_start; each bit lasts CLKS_PER_BIT clk cycles.
// Ports   : clk      - system clock, rising edge
//           rst      - asynchronous active-high reset
//           tx_start - send request, honoured only when the transmitter is free
//           tx_data  - byte captured when tx_start is accepted
//           tx       - serial output, idle high

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;

  logic bit_end;
  logic accept;

  assign bit_end = (cnt == CNT_LAST);

  // The last cycle of STOP counts as the return to idle, so a held tx_start
  // chains frames with no extra idle cycle between them.
  assign accept = tx_start &&
                  ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

  // tx is a flop with asynchronous set so reset forces the line high at once
  // and the pin never sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      tx_q    <= 1'b1;
    end else if (accept) begin
      state   <= ST_START;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= tx_data;
      tx_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          tx_q <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= ST_DATA;
            tx_q    <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin  // ST_STOP
          if (bit_end) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
          tx_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex 8N1 UART top, structural only
//
// Purpose : pairs an independent transmitter and receiver sharing clk/rst.
// Ports   : clk, rst          - system clock and asynchronous active-high reset
//           tx_start, tx_data - transmit request and byte
//           rx                - serial input (may be looped back from tx)
//           tx                - serial output
//           rx_data, rx_done  - received byte and its one-cycle strobe

module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_done (rx_done)
  );

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - self-checking bench for the uart top

module tb_uart;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_ext = 1'b1;
  logic       loop_en = 1'b1;
  logic       rx_line;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_done;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign rx_line = loop_en ? tx : rx_ext;

  uart #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .rx       (rx_line),
    .tx       (tx),
    .rx_data  (rx_data),
    .rx_done  (rx_done)
  );

  // Received-byte scoreboard fed by every rx_done pulse.
  logic [7:0] done_q[$];
  int         done_cyc = 0;
  logic       prev_done = 1'b0;
  int         double_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (rx_done === 1'b1) begin
        done_q.push_back(rx_data);
        done_cyc = cyc;
        if (prev_done) double_cnt++;
      end
      prev_done = rx_done;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // Start a transmission at a negedge; tx must be low one cycle later.
  task automatic start_tx(input logic [7:0] d, input string tag);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    vec++;
    if (tx !== 1'b0) begin
      errs++;
      $display("FAIL %s start: tx=%b, expected 0 one cycle after tx_start", tag, tx);
    end
  endtask

  // Checks a whole frame cycle-by-cycle against {stop, data, start}.
  // Starts at the negedge where the start bit is first visible and returns
  // at the negedge right after the stop bit ends.
  task automatic check_tx_frame(input logic [7:0] d, input int drop_at,
                                input logic [7:0] next_data, input string tag);
    logic [9:0] bits;
    int bad[10];
    bits = {1'b1, d, 1'b0};
    for (int b = 0; b < 10; b++) bad[b] = 0;
    for (int i = 0; i < 10 * C; i++) begin
      if (tx !== bits[i / C]) bad[i / C]++;
      if (i == 0) tx_data = next_data;
      if (i == drop_at) tx_start = 1'b0;
      @(negedge clk);
    end
    for (int b = 0; b < 10; b++) begin
      vec++;
      if (bad[b] != 0) begin
        errs++;
        $display("FAIL %s bit%0d: tx wrong in %0d of %0d cycles, expected level %b",
                 tag, b, bad[b], C, bits[b]);
      end
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_ext = bits[i];
      repeat (C) @(negedge clk);
    end
    rx_ext = 1'b1;
  endtask

  task automatic check_rx(input logic [7:0] exp, input string tag);
    vec++;
    if (done_q.size() != 1) begin
      errs++;
      $display("FAIL %s rx_done count: got %0d pulses, expected 1", tag, done_q.size());
    end else begin
      vec++;
      if (done_q[0] !== exp) begin
        errs++;
        $display("FAIL %s rx_data: got %h, expected %h", tag, done_q[0], exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++;
      if (tx !== 1'b1 || rx_data !== 8'h00 || rx_done !== 1'b0) begin
        errs++;
        $display("FAIL reset cycle%0d: tx=%b rx_data=%h rx_done=%b, expected 1/00/0",
                 i, tx, rx_data, rx_done);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    int t0;
    int lat;
    loop_en = 1'b1;
    done_q.delete();
    start_tx(8'hA5, "a5");
    t0 = cyc;
    check_tx_frame(8'hA5, 1, 8'hA5, "a5");
    check_rx(8'hA5, "a5");
    lat = done_cyc - t0;
    vec++;
    if (lat < 153 || lat > 157) begin
      errs++;
      $display("FAIL a5 latency: got %0d cycles, expected 153..157", lat);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    loop_en = 1'b1;
    done_q.delete();
    start_tx(8'h00, "b2b");
    check_tx_frame(8'h00, -1, 8'hFF, "b2b0");
    check_tx_frame(8'hFF, 0, 8'hFF, "b2b1");
    repeat (10) @(negedge clk);
    vec++;
    if (done_q.size() != 2) begin
      errs++;
      $display("FAIL b2b rx_done count: got %0d, expected 2", done_q.size());
    end else begin
      vec++;
      if (done_q[0] !== 8'h00 || done_q[1] !== 8'hFF) begin
        errs++;
        $display("FAIL b2b rx_data: got %h,%h, expected 00,ff", done_q[0], done_q[1]);
      end
    end
  endtask

  task automatic test_glitch();
    loop_en = 1'b0;
    rx_ext  = 1'b1;
    done_q.delete();
    repeat (5) @(negedge clk);
    rx_ext = 1'b0;
    repeat (4) @(negedge clk);
    rx_ext = 1'b1;
    repeat (40) @(negedge clk);
    vec++;
    if (done_q.size() != 0) begin
      errs++;
      $display("FAIL glitch: got %0d rx_done pulses, expected 0", done_q.size());
    end
    drive_rx_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check_rx(8'h3C, "glitch_3c");
  endtask

  task automatic test_framing_error();
    logic [7:0] r;
    loop_en = 1'b0;
    done_q.delete();
    drive_rx_frame(8'h81, 1'b0);
    repeat (30) @(negedge clk);
    vec++;
    if (done_q.size() != 0) begin
      errs++;
      $display("FAIL framing rx_done: got %0d pulses, expected 0", done_q.size());
    end
    vec++;
    if (rx_data !== 8'h3C) begin
      errs++;
      $display("FAIL framing rx_data: got %h, expected 3c held", rx_data);
    end
    r = 8'($urandom);
    drive_rx_frame(r, 1'b1);
    repeat (10) @(negedge clk);
    check_rx(r, "framing_recover");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r;
    loop_en = 1'b1;
    done_q.delete();
    start_tx(8'h4A, "midrst");
    tx_start = 1'b0;
    // Land in the middle of data bit 4 (frame position 5), which is 0 for 4A.
    repeat (5 * C + C / 2) @(negedge clk);
    vec++;
    if (tx !== 1'b0) begin
      errs++;
      $display("FAIL midrst pre: tx=%b, expected 0 during bit4 of 4a", tx);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (tx !== 1'b1) begin
      errs++;
      $display("FAIL midrst async: tx=%b, expected 1 before next clock edge", tx);
    end
    repeat (3) @(negedge clk);
    vec++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0) begin
      errs++;
      $display("FAIL midrst rx: rx_data=%h rx_done=%b, expected 00/0", rx_data, rx_done);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (done_q.size() != 0) begin
      errs++;
      $display("FAIL midrst spurious: got %0d rx_done pulses, expected 0", done_q.size());
    end
    r = 8'($urandom);
    start_tx(r, "midrst_post");
    check_tx_frame(r, 0, r, "midrst_post");
    repeat (5) @(negedge clk);
    check_rx(r, "midrst_post");
  endtask

  task automatic test_random_loopback();
    logic [7:0] r;
    int hold;
    loop_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      done_q.delete();
      r    = 8'($urandom);
      hold = int'($urandom_range(1, 4));
      start_tx(r, "rand_lb");
      check_tx_frame(r, hold - 1, r, "rand_lb");
      repeat (int'($urandom_range(2, 6))) @(negedge clk);
      check_rx(r, "rand_lb");
    end
  endtask

  task automatic test_random_rx();
    logic [7:0] r;
    loop_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      done_q.delete();
      r = 8'($urandom);
      repeat (int'($urandom_range(1, 8))) @(negedge clk);
      drive_rx_frame(r, 1'b1);
      repeat (5) @(negedge clk);
      check_rx(r, "rand_rx");
    end
  endtask

  task automatic test_done_pulse_width();
    vec++;
    if (double_cnt != 0) begin
      errs++;
      $display("FAIL done_width: rx_done high on consecutive cycles %0d times, expected 0",
               double_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_random_loopback();
    test_random_rx();
    test_done_pulse_width();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
